// File: rtl/ctrl_codigo.sv
// rtl/ctrl_codigo.sv - keypad code lock controller: 4-digit BCD entry, verify, open window, lockout
module ctrl_codigo #(
    parameter logic [15:0] CODIGO       = 16'h1234,
    parameter int          MAX_INTENTOS = 3,
    parameter int          T_ABIERTO    = 500,
    parameter int          T_BLOQUEO    = 3000,
    parameter int          HOLDOFF      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  digito,
    input  logic        cambio_digito,
    input  logic        enter_sync,
    output logic [15:0] codigo,
    output logic [2:0]  n_digitos,
    output logic        abierto,
    output logic        error,
    output logic        bloqueado,
    output logic [1:0]  intentos,
    output logic [2:0]  estado
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ENTRADA   = 3'd1,
        VERIFICAR = 3'd2,
        ABIERTO   = 3'd3,
        BLOQUEO   = 3'd4
    } estado_t;

    localparam int T_MAX = (T_ABIERTO > T_BLOQUEO) ? T_ABIERTO : T_BLOQUEO;
    localparam int TW    = $clog2(T_MAX + 1);
    localparam int HW    = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

    estado_t         st;
    logic            cambio_prev;
    logic            enter_prev;
    logic [HW-1:0]   hold_cnt;
    logic [TW-1:0]   timer;
    logic            key_ev;
    logic            enter_ev;
    logic [1:0]      intentos_inc;

    assign estado = st;

    always_comb begin
        key_ev       = cambio_digito & ~cambio_prev & (hold_cnt >= HW'(HOLDOFF));
        enter_ev     = enter_sync & ~enter_prev;
        intentos_inc = (intentos == 2'(MAX_INTENTOS)) ? intentos : intentos + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= IDLE;
            codigo      <= 16'h0000;
            n_digitos   <= 3'd0;
            abierto     <= 1'b0;
            error       <= 1'b0;
            bloqueado   <= 1'b0;
            intentos    <= 2'd0;
            timer       <= '0;
            hold_cnt    <= HW'(HOLDOFF);
            cambio_prev <= cambio_digito;
            enter_prev  <= enter_sync;
        end else begin
            // Edge detectors and holdoff run in every state so held keys never fire on state entry
            cambio_prev <= cambio_digito;
            enter_prev  <= enter_sync;
            if (cambio_digito) begin
                hold_cnt <= '0;
            end else if (hold_cnt < HW'(HOLDOFF)) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
            error <= 1'b0;

            case (st)
                IDLE, ENTRADA: begin
                    if (enter_ev) begin
                        if (n_digitos == 3'd4) begin
                            st <= VERIFICAR;
                        end else begin
                            error     <= 1'b1;
                            codigo    <= 16'h0000;
                            n_digitos <= 3'd0;
                            st        <= IDLE;
                        end
                    end else if (key_ev) begin
                        if (digito <= 5'd9 && n_digitos < 3'd4) begin
                            codigo    <= {codigo[11:0], digito[3:0]};
                            n_digitos <= n_digitos + 3'd1;
                            st        <= ENTRADA;
                        end else if (digito == 5'hE && n_digitos != 3'd0) begin
                            codigo    <= {4'h0, codigo[15:4]};
                            n_digitos <= n_digitos - 3'd1;
                            st        <= (n_digitos == 3'd1) ? IDLE : ENTRADA;
                        end else if (digito == 5'hF) begin
                            codigo    <= 16'h0000;
                            n_digitos <= 3'd0;
                            st        <= IDLE;
                        end
                    end
                end

                VERIFICAR: begin
                    codigo    <= 16'h0000;
                    n_digitos <= 3'd0;
                    if (codigo == CODIGO) begin
                        abierto  <= 1'b1;
                        intentos <= 2'd0;
                        timer    <= TW'(T_ABIERTO - 1);
                        st       <= ABIERTO;
                    end else begin
                        error    <= 1'b1;
                        intentos <= intentos_inc;
                        if (intentos_inc == 2'(MAX_INTENTOS)) begin
                            bloqueado <= 1'b1;
                            timer     <= TW'(T_BLOQUEO - 1);
                            st        <= BLOQUEO;
                        end else begin
                            st <= IDLE;
                        end
                    end
                end

                ABIERTO: begin
                    if (timer == '0) begin
                        abierto <= 1'b0;
                        st      <= IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                BLOQUEO: begin
                    if (timer == '0) begin
                        bloqueado <= 1'b0;
                        intentos  <= 2'd0;
                        st        <= IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_codigo.sv
// tb/tb_ctrl_codigo.sv - randomized and directed bench for ctrl_codigo against a behavioural model
module tb_ctrl_codigo;
    localparam int HOLDOFF = 8;
    localparam int T_AB    = 500;
    localparam int T_BL    = 3000;
    localparam int MAXI    = 3;
    localparam int COD     = 32'h1234;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  digito = 5'd16;
    logic        cambio = 1'b0;
    logic        enter = 1'b0;
    logic [15:0] codigo;
    logic [2:0]  n_digitos;
    logic        abierto, error, bloqueado;
    logic [1:0]  intentos;
    logic [2:0]  estado;

    int n_checks = 0;
    int n_errors = 0;
    int cycles = 0;

    ctrl_codigo dut (
        .clk(clk), .rst(rst), .digito(digito), .cambio_digito(cambio),
        .enter_sync(enter), .codigo(codigo), .n_digitos(n_digitos),
        .abierto(abierto), .error(error), .bloqueado(bloqueado),
        .intentos(intentos), .estado(estado)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cycles);
        end
    endtask

    // Behavioural model: the entry buffer is a list of digits, modes are countdowns
    int q[$];
    int open_left = 0, lock_left = 0, fails = 0, m_low = 0;
    bit verifying = 0, m_err = 0, m_cprev = 0, m_eprev = 0, mv = 0;

    function automatic int qval();
        int v = 0;
        foreach (q[i]) v = v * 16 + q[i];
        return v;
    endfunction

    function automatic int exp_estado();
        if (lock_left > 0) return 4;
        if (open_left > 0) return 3;
        if (verifying) return 2;
        return (q.size() > 0) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        bit key;
        bit ent;
        if (rst) begin
            q.delete();
            open_left = 0; lock_left = 0; fails = 0; verifying = 0; m_err = 0;
            m_low = HOLDOFF; mv = 1;
        end else begin
            key = cambio && !m_cprev && (m_low >= HOLDOFF);
            ent = enter && !m_eprev;
            m_err = 0;
            if (lock_left > 0) begin
                lock_left--;
                if (lock_left == 0) fails = 0;
            end else if (open_left > 0) begin
                open_left--;
            end else if (verifying) begin
                verifying = 0;
                if (qval() == COD) begin
                    open_left = T_AB;
                    fails = 0;
                end else begin
                    m_err = 1;
                    if (fails < MAXI) fails++;
                    if (fails == MAXI) lock_left = T_BL;
                end
                q.delete();
            end else if (ent) begin
                if (q.size() == 4) verifying = 1;
                else begin m_err = 1; q.delete(); end
            end else if (key) begin
                if (digito < 10 && q.size() < 4) q.push_back(int'(digito));
                else if (digito == 14 && q.size() > 0) void'(q.pop_back());
                else if (digito == 15) q.delete();
            end
            m_low = cambio ? 0 : ((m_low < 1000) ? m_low + 1 : m_low);
        end
        m_cprev = cambio;
        m_eprev = enter;
    end

    always @(negedge clk) begin
        cycles++;
        if (mv) begin
            chk("m_codigo", codigo, qval());
            chk("m_n_digitos", n_digitos, q.size());
            chk("m_abierto", abierto, open_left > 0);
            chk("m_bloqueado", bloqueado, lock_left > 0);
            chk("m_error", error, m_err);
            chk("m_intentos", intentos, fails);
            chk("m_estado", estado, exp_estado());
        end
    end

    task automatic press(input logic [4:0] d, input int low);
        digito = d; cambio = 1'b1;
        @(negedge clk);
        cambio = 1'b0; digito = 5'd16;
        repeat (low) @(negedge clk);
    endtask

    task automatic press_code(input logic [15:0] v);
        for (int i = 3; i >= 0; i--) press({1'b0, v[i*4 +: 4]}, 10);
    endtask

    task automatic do_enter();
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int g = 0;
        while (estado !== 3'd0 && g < limit) begin @(negedge clk); g++; end
        chk("idle_reached", estado, 0);
    endtask

    initial begin
        int cnt;
        int r;
        repeat (3) @(negedge clk);
        chk("rst_codigo", codigo, 0);
        chk("rst_n", n_digitos, 0);
        chk("rst_estado", estado, 0);
        chk("rst_outs", {abierto, error, bloqueado, intentos}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Correct code opens for the full window
        press_code(16'h1234);
        chk("a_codigo", codigo, 32'h1234);
        chk("a_n", n_digitos, 4);
        do_enter();
        chk("a_verif", estado, 2);
        @(negedge clk);
        cnt = 0;
        while (abierto === 1'b1 && cnt < 1000) begin cnt++; @(negedge clk); end
        chk("a_open_cycles", cnt, 500);
        chk("a_intentos", intentos, 0);
        chk("a_idle", estado, 0);

        // Fifth digit ignored, backspace then retype
        press(5'd1, 10); press(5'd2, 10); press(5'd3, 10); press(5'd5, 10);
        press(5'd6, 10); press(5'hE, 10); press(5'd4, 10);
        chk("b_codigo", codigo, 32'h1234);
        do_enter();
        @(negedge clk);
        chk("b_open", abierto, 1);
        wait_idle(1000);

        // Three wrong entries lead to lockout
        for (int k = 1; k <= 3; k++) begin
            press_code(16'h9999);
            do_enter();
            chk("c_verif", estado, 2);
            @(negedge clk);
            chk("c_err", error, 1);
            chk("c_intentos", intentos, k);
            if (k < 3) begin
                @(negedge clk);
                chk("c_err_one_cycle", error, 0);
            end
        end
        chk("c_locked", bloqueado, 1);
        cnt = 0;
        while (bloqueado === 1'b1 && cnt < 5000) begin
            cnt++;
            digito = 5'd1;
            cambio = (cnt % 20 == 0);
            @(negedge clk);
        end
        cambio = 1'b0; digito = 5'd16;
        chk("c_lock_cycles", cnt, 3000);
        chk("c_intentos_clear", intentos, 0);
        chk("c_n_after", n_digitos, 0);
        repeat (10) @(negedge clk);

        // Re-press within holdoff is rejected; short enter errors
        digito = 5'd7; cambio = 1'b1; @(negedge clk);
        cambio = 1'b0; repeat (3) @(negedge clk);
        cambio = 1'b1; @(negedge clk);
        cambio = 1'b0; digito = 5'd16; repeat (10) @(negedge clk);
        chk("d_n", n_digitos, 1);
        chk("d_codigo", codigo, 7);
        do_enter();
        chk("d_err", error, 1);
        chk("d_n_clear", n_digitos, 0);
        chk("d_intentos", intentos, 0);

        // Enter beats a simultaneous key, short and full buffers
        press(5'd1, 10); press(5'd2, 10); press(5'd3, 10);
        digito = 5'd4; cambio = 1'b1; enter = 1'b1; @(negedge clk);
        cambio = 1'b0; enter = 1'b0; digito = 5'd16;
        chk("e_err", error, 1);
        chk("e_n", n_digitos, 0);
        repeat (10) @(negedge clk);
        press_code(16'h1234);
        digito = 5'd5; cambio = 1'b1; enter = 1'b1; @(negedge clk);
        cambio = 1'b0; enter = 1'b0; digito = 5'd16;
        chk("e_verif", estado, 2);
        chk("e_codigo", codigo, 32'h1234);
        @(negedge clk);
        chk("e_open", abierto, 1);
        repeat (99) @(negedge clk);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        chk("e_rst_abierto", abierto, 0);
        chk("e_rst_estado", estado, 0);

        // Randomized traffic
        while (cycles < 60000) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                rst = 1'b1; @(negedge clk); rst = 1'b0;
            end else if (r < 15) begin
                enter = 1'b1;
                if ($urandom_range(0, 3) == 0) begin
                    cambio = 1'b1; digito = 5'($urandom_range(0, 17));
                end
                repeat ($urandom_range(1, 2)) @(negedge clk);
                enter = 1'b0; cambio = 1'b0; digito = 5'd16;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end else if (r < 30) begin
                for (int i = 1; i <= 4; i++) press(5'(i), $urandom_range(6, 12));
            end else if (r < 85) begin
                digito = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(1, 4))
                                                    : 5'($urandom_range(0, 17));
                cambio = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                cambio = 1'b0; digito = 5'd16;
                repeat ($urandom_range(1, 12)) @(negedge clk);
            end else begin
                repeat ($urandom_range(1, 20)) @(negedge clk);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
